// File: rtl/cpu_run_ctrl_pkg.sv
// Shared definitions for the MIPS run/stop sequencer: state encodings and
// the bundle of debounced button pulses.
package cpu_run_ctrl_pkg;

  localparam logic [1:0] ST_STOP = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_STEP = 2'd2;
  localparam logic [1:0] ST_HALT = 2'd3;

  typedef struct packed {
    logic go;
    logic step;
    logic clr;
  } btn_pulse_t;

  // The core and the statistics block advance only in these two states.
  function automatic logic is_enabled(input logic [1:0] st);
    return (st == ST_RUN) || (st == ST_STEP);
  endfunction

endpackage

// File: rtl/cpu_run_ctrl_btn_debounce.sv
// Button conditioner: 2-FF synchronizer, stability counter, and a one-cycle
// pulse on each accepted rising level.
module btn_debounce
  import cpu_run_ctrl_pkg::*;
#(
  parameter int DB_CYCLES = 20
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn_raw,
  output logic o_pulse
);

  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] LIM = CW'(DB_CYCLES - 1);

  logic [1:0]    r_sync;
  logic [CW-1:0] r_cnt;
  logic          r_level;
  logic          r_pulse;

  // r_cnt counts consecutive synchronized samples that differ from r_level;
  // the DB_CYCLES-th such sample flips the accepted level.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync  <= 2'b00;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], i_btn_raw};
      r_pulse <= 1'b0;
      if (r_sync[1] == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == LIM) begin
        r_level <= r_sync[1];
        r_cnt   <= '0;
        r_pulse <= r_sync[1];
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_pulse = r_pulse;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/stop sequencer for the single-cycle MIPS core: button-driven FSM,
// enabled-cycle counter, watchdog stop and statistics clear pulse.
module cpu_run_ctrl
  import cpu_run_ctrl_pkg::*;
#(
  parameter int DB_CYCLES = 20,
  parameter int CNT_W     = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_btn_go,
  input  logic             i_btn_step,
  input  logic             i_btn_clr,
  input  logic             i_halt,
  input  logic [CNT_W-1:0] i_wdog_limit,
  output logic             o_cpu_en,
  output logic             o_stat_clr,
  output logic [1:0]       o_state,
  output logic [CNT_W-1:0] o_run_cycles,
  output logic             o_wdog_trip
);

  btn_pulse_t       w_p;
  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [CNT_W-1:0] r_run;
  logic             r_trip;
  logic             r_stat_clr;
  logic             w_en;
  logic             w_hit;
  logic             w_clr_acc;
  logic             w_trip_set;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_go (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_btn_raw(i_btn_go), .o_pulse(w_p.go)
  );
  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_step (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_btn_raw(i_btn_step), .o_pulse(w_p.step)
  );
  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_clr (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_btn_raw(i_btn_clr), .o_pulse(w_p.clr)
  );

  assign w_en = is_enabled(r_state);

  // The hit cycle is itself an enabled cycle, so the count lands on the limit.
  assign w_hit = w_en && (i_wdog_limit != '0) &&
                 ((r_run + CNT_W'(1)) == i_wdog_limit);

  // Clear is only honoured where the core is parked; RUN/STEP never see it.
  assign w_clr_acc = w_p.clr && ((r_state == ST_STOP) || (r_state == ST_HALT));

  always_comb begin
    w_state_nxt = r_state;
    w_trip_set  = 1'b0;
    case (r_state)
      ST_STOP: begin
        if (w_p.clr)       w_state_nxt = ST_STOP;
        else if (w_p.go)   w_state_nxt = ST_RUN;
        else if (w_p.step) w_state_nxt = ST_STEP;
      end
      ST_RUN: begin
        if (i_halt) begin
          w_state_nxt = ST_HALT;
        end else if (w_hit) begin
          w_state_nxt = ST_STOP;
          w_trip_set  = 1'b1;
        end else if (w_p.go) begin
          w_state_nxt = ST_STOP;
        end
      end
      ST_STEP: begin
        if (i_halt) begin
          w_state_nxt = ST_HALT;
        end else if (w_hit) begin
          w_state_nxt = ST_HALT;
          w_trip_set  = 1'b1;
        end else begin
          w_state_nxt = ST_STOP;
        end
      end
      ST_HALT: begin
        if (w_p.clr) w_state_nxt = ST_STOP;
      end
      default: w_state_nxt = ST_STOP;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_STOP;
      r_run      <= '0;
      r_trip     <= 1'b0;
      r_stat_clr <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_stat_clr <= w_clr_acc;
      if (w_clr_acc) begin
        r_run  <= '0;
        r_trip <= 1'b0;
      end else begin
        if (w_en && !(&r_run)) r_run <= r_run + CNT_W'(1);
        if (w_trip_set)        r_trip <= 1'b1;
      end
    end
  end

  // Moore decode straight from the state flop so reset drops it at once.
  assign o_cpu_en     = w_en;
  assign o_stat_clr   = r_stat_clr;
  assign o_state      = r_state;
  assign o_run_cycles = r_run;
  assign o_wdog_trip  = r_trip;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl (DB_CYCLES=4): directed scenarios plus random button
// traffic, every cycle compared against an event-level reference model.
module tb_cpu_run_ctrl;

  localparam int DB = 4;
  localparam int CW = 32;
  localparam longint RUN_MAX = (longint'(1) << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          btn_go = 1'b0;
  logic          btn_step = 1'b0;
  logic          btn_clr = 1'b0;
  logic          halt = 1'b0;
  logic [CW-1:0] wdog_limit = '0;
  logic          cpu_en;
  logic          stat_clr;
  logic [1:0]    state;
  logic [CW-1:0] run_cycles;
  logic          wdog_trip;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: mode by spec number, counters as plain integers, and a
  // per-button sample history from which accepted edges are derived.
  int        m_mode;
  longint    m_run;
  bit        m_trip;
  bit        m_clr;
  bit        m_lvl [3];
  bit        m_pul [3];
  bit [15:0] m_hist [3];

  always #5 clk = ~clk;

  cpu_run_ctrl #(.DB_CYCLES(DB), .CNT_W(CW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_btn_go(btn_go), .i_btn_step(btn_step),
    .i_btn_clr(btn_clr), .i_halt(halt), .i_wdog_limit(wdog_limit),
    .o_cpu_en(cpu_en), .o_stat_clr(stat_clr), .o_state(state),
    .o_run_cycles(run_cycles), .o_wdog_trip(wdog_trip)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0;
    m_run  = 0;
    m_trip = 1'b0;
    m_clr  = 1'b0;
    for (int b = 0; b < 3; b++) begin
      m_lvl[b]  = 1'b0;
      m_pul[b]  = 1'b0;
      m_hist[b] = '0;
    end
  endtask

  task automatic check_all();
    chk("state", 64'(state), 64'(m_mode));
    chk("cpu_en", 64'(cpu_en), 64'(m_mode == 1 || m_mode == 2));
    chk("stat_clr", 64'(stat_clr), 64'(m_clr));
    chk("run_cycles", 64'(run_cycles), 64'(m_run));
    chk("wdog_trip", 64'(wdog_trip), 64'(m_trip));
  endtask

  // Advance model and DUT by one clock edge, then compare.
  task automatic tick();
    bit     raw [3];
    bit     en, hit, clr_acc, all_eq, want;
    int     ev, nmode;
    longint nrun;
    bit     ntrip;
    raw[0] = btn_go;
    raw[1] = btn_step;
    raw[2] = btn_clr;
    en  = (m_mode == 1) || (m_mode == 2);
    hit = en && (wdog_limit != 0) && (m_run + 1 == longint'(wdog_limit));
    // Highest-priority event this cycle: 1 halt, 2 watchdog, 3 clr, 4 go, 5 step.
    if (en && halt)       ev = 1;
    else if (hit)         ev = 2;
    else if (m_pul[2])    ev = 3;
    else if (m_pul[0])    ev = 4;
    else if (m_pul[1])    ev = 5;
    else                  ev = 0;
    nmode   = m_mode;
    ntrip   = m_trip;
    clr_acc = 1'b0;
    if (m_mode == 2) begin
      nmode = (ev == 1 || ev == 2) ? 3 : 0;
      if (ev == 2) ntrip = 1'b1;
    end else if (m_mode == 1) begin
      if (ev == 1) nmode = 3;
      if (ev == 2) begin nmode = 0; ntrip = 1'b1; end
      if (ev == 4) nmode = 0;
      if (ev == 3 && m_pul[0]) nmode = 0;
    end else begin
      if (ev == 3) clr_acc = 1'b1;
      if (m_mode == 0 && ev == 4) nmode = 1;
      if (m_mode == 0 && ev == 5) nmode = 2;
      if (m_mode == 3 && ev == 3) nmode = 0;
    end
    if (clr_acc)   nrun = 0;
    else if (en)   nrun = (m_run >= RUN_MAX) ? RUN_MAX : m_run + 1;
    else           nrun = m_run;
    if (clr_acc) ntrip = 1'b0;
    for (int b = 0; b < 3; b++) begin
      want   = !m_lvl[b];
      all_eq = 1'b1;
      for (int i = 1; i <= DB; i++) if (m_hist[b][i] != want) all_eq = 1'b0;
      m_pul[b] = 1'b0;
      if (all_eq) begin
        m_lvl[b] = want;
        m_pul[b] = want;
      end
      m_hist[b] = {m_hist[b][14:0], raw[b]};
    end
    m_mode = nmode;
    m_run  = nrun;
    m_trip = ntrip;
    m_clr  = clr_acc;
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int act, hold, gap;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", 64'(state), 64'd0);
    chk("rst_cpu_en", 64'(cpu_en), 64'd0);
    chk("rst_stat_clr", 64'(stat_clr), 64'd0);
    chk("rst_run", 64'(run_cycles), 64'd0);
    chk("rst_trip", 64'(wdog_trip), 64'd0);
    rst_n = 1'b1;
    ticks(3);

    // Go from STOP: pulse after 6 cycles, RUN on the 7th edge, then counting.
    btn_go = 1'b1;
    ticks(6);
    chk("t1_pre_run", 64'(state), 64'd0);
    tick();
    chk("t1_run", 64'(state), 64'd1);
    chk("t1_en", 64'(cpu_en), 64'd1);
    ticks(3);
    btn_go = 1'b0;
    ticks(10);
    chk("t1_count", 64'(run_cycles), 64'd13);
    btn_go = 1'b1;
    ticks(7);
    chk("t1_pause", 64'(state), 64'd0);
    chk("t1_pause_run", 64'(run_cycles), 64'd20);
    btn_go = 1'b0;
    ticks(8);

    // Clear, then a single step.
    btn_clr = 1'b1;
    ticks(7);
    chk("t2_stat_clr", 64'(stat_clr), 64'd1);
    chk("t2_clr_run", 64'(run_cycles), 64'd0);
    btn_clr = 1'b0;
    ticks(8);
    btn_step = 1'b1;
    ticks(7);
    chk("t2_step_state", 64'(state), 64'd2);
    chk("t2_step_en", 64'(cpu_en), 64'd1);
    tick();
    chk("t2_step_back", 64'(state), 64'd0);
    chk("t2_step_run", 64'(run_cycles), 64'd1);
    btn_step = 1'b0;
    ticks(8);

    // Halt arrives together with a go pulse in RUN; halt wins.
    btn_go = 1'b1;
    ticks(7);
    btn_go = 1'b0;
    ticks(8);
    btn_go = 1'b1;
    ticks(6);
    halt = 1'b1;
    tick();
    chk("t3_halt", 64'(state), 64'd3);
    chk("t3_halt_en", 64'(cpu_en), 64'd0);
    btn_go = 1'b0;
    ticks(8);
    btn_step = 1'b1;
    ticks(10);
    btn_step = 1'b0;
    ticks(8);
    chk("t3_ignored", 64'(state), 64'd3);
    halt = 1'b0;
    btn_clr = 1'b1;
    ticks(7);
    chk("t3_stat_clr", 64'(stat_clr), 64'd1);
    chk("t3_stop", 64'(state), 64'd0);
    chk("t3_run0", 64'(run_cycles), 64'd0);
    tick();
    chk("t3_clr_1cyc", 64'(stat_clr), 64'd0);
    btn_clr = 1'b0;
    ticks(8);

    // Watchdog at 100 enabled cycles, then clear drops the trip flag.
    wdog_limit = 32'd100;
    btn_go = 1'b1;
    ticks(7);
    btn_go = 1'b0;
    ticks(110);
    chk("t4_state", 64'(state), 64'd0);
    chk("t4_trip", 64'(wdog_trip), 64'd1);
    chk("t4_run", 64'(run_cycles), 64'd100);
    btn_clr = 1'b1;
    ticks(7);
    chk("t4_trip_clr", 64'(wdog_trip), 64'd0);
    btn_clr = 1'b0;
    ticks(8);
    wdog_limit = '0;

    // Bouncing step button never settles long enough to be accepted.
    for (int i = 0; i < 10; i++) begin
      btn_step = ~btn_step;
      ticks(2);
    end
    btn_step = 1'b0;
    ticks(10);
    chk("t5_bounce_state", 64'(state), 64'd0);
    chk("t5_bounce_run", 64'(run_cycles), 64'd0);

    // Random traffic against the model.
    for (int it = 0; it < 60; it++) begin
      act  = int'($urandom_range(0, 6));
      hold = int'($urandom_range(5, 12));
      gap  = int'($urandom_range(5, 12));
      if ($urandom_range(0, 3) == 0)
        wdog_limit = ($urandom_range(0, 1) == 0) ? '0 : 32'($urandom_range(3, 60));
      case (act)
        0: begin btn_go = 1'b1; ticks(hold); btn_go = 1'b0; ticks(gap); end
        1: begin btn_step = 1'b1; ticks(hold); btn_step = 1'b0; ticks(gap); end
        2: begin btn_clr = 1'b1; ticks(hold); btn_clr = 1'b0; ticks(gap); end
        3: begin halt = 1'b1; ticks(int'($urandom_range(1, 5))); halt = 1'b0; ticks(gap); end
        4: begin
          for (int i = 0; i < hold; i++) begin
            btn_go = 1'($urandom_range(0, 1));
            tick();
          end
          btn_go = 1'b0;
          ticks(gap);
        end
        default: ticks(hold + gap);
      endcase
    end
    wdog_limit = '0;
    ticks(10);

    // Asynchronous reset while running with 37 counted cycles.
    if (state == 2'd3 || state == 2'd2) begin
      btn_clr = 1'b1;
      ticks(8);
      btn_clr = 1'b0;
      ticks(8);
    end
    if (state != 2'd0) begin
      btn_go = 1'b1;
      ticks(8);
      btn_go = 1'b0;
      ticks(8);
    end
    btn_clr = 1'b1;
    ticks(8);
    btn_clr = 1'b0;
    ticks(8);
    btn_go = 1'b1;
    ticks(7);
    btn_go = 1'b0;
    ticks(37);
    chk("t6_run37", 64'(run_cycles), 64'd37);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_en", 64'(cpu_en), 64'd0);
    chk("t6_async_run", 64'(run_cycles), 64'd0);
    model_reset();
    #2;
    rst_n = 1'b1;
    tick();
    chk("t6_after_state", 64'(state), 64'd0);
    ticks(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
